// File: rtl/rx_deserializer_pkg.sv
// rx_deserializer_pkg: shared line-state encoding and deserializer sizing constants.
package rx_deserializer_pkg;
  localparam int STUFF_LIMIT = 6;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {LS_SE0 = 2'b00, LS_J = 2'b01, LS_K = 2'b10, LS_SE1 = 2'b11} line_t;
endpackage

// File: rtl/rx_bit_unstuff.sv
// rx_bit_unstuff: NRZI decode of J/K samples and removal of stuffed zeros.
module rx_bit_unstuff
  import rx_deserializer_pkg::*;
#(
  parameter int STUFF_LIMIT = rx_deserializer_pkg::STUFF_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic j,
  input  logic k,
  input  logic se0,
  input  logic shift_en,
  output logic dbit,
  output logic bit_valid,
  output logic stuff_violation
);
  localparam int OW = $clog2(STUFF_LIMIT + 1);
  line_t prev_line;
  line_t line;
  logic [OW-1:0] ones_cnt;
  logic jk;
  logic at_limit;
  always_comb begin
    jk = sample & (j ^ k) & ~se0;
    line = k ? LS_K : LS_J;
    at_limit = ones_cnt == OW'(STUFF_LIMIT);
    dbit = line == prev_line;
    bit_valid = jk & shift_en & ~at_limit;
    stuff_violation = jk & shift_en & at_limit & dbit;
  end
  // the bit following a full run of ones is the stuff bit: always consumed, never counted
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_line <= LS_J;
      ones_cnt <= '0;
    end else begin
      if (jk) prev_line <= line;
      if (!shift_en || (sample && se0) || (jk && at_limit)) ones_cnt <= '0;
      else if (jk) ones_cnt <= dbit ? ones_cnt + 1'b1 : '0;
    end
  end
endmodule

// File: rtl/rx_deserializer.sv
// rx_deserializer: assembles unstuffed bits into bytes, flags stuffing and framing errors.
module rx_deserializer
  import rx_deserializer_pkg::*;
#(
  parameter int STUFF_LIMIT = rx_deserializer_pkg::STUFF_LIMIT,
  parameter int BYTE_W = rx_deserializer_pkg::BYTE_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              sample,
  input  logic              J,
  input  logic              K,
  input  logic              SE0,
  input  logic              shift_en,
  output logic [BYTE_W-1:0] DataOut,
  output logic              RX_valid,
  output logic              stuff_err,
  output logic              byte_err
);
  localparam int CW = $clog2(BYTE_W);
  logic dbit;
  logic bit_valid;
  logic stuff_violation;
  logic err_lock;
  logic [CW-1:0] bit_cnt;
  logic [BYTE_W-1:0] shreg;
  rx_bit_unstuff #(.STUFF_LIMIT(STUFF_LIMIT)) u_unstuff (
    .clk(CLK),
    .rst(RST),
    .sample(sample),
    .j(J),
    .k(K),
    .se0(SE0),
    .shift_en(shift_en),
    .dbit(dbit),
    .bit_valid(bit_valid),
    .stuff_violation(stuff_violation)
  );
  // once locked, the rest of the packet is ignored until the control FSM drops shift_en
  always_ff @(posedge CLK) begin
    if (RST) begin
      DataOut <= '0;
      RX_valid <= 1'b0;
      stuff_err <= 1'b0;
      byte_err <= 1'b0;
      err_lock <= 1'b0;
      bit_cnt <= '0;
      shreg <= '0;
    end else begin
      RX_valid <= 1'b0;
      stuff_err <= 1'b0;
      byte_err <= 1'b0;
      if (!shift_en) begin
        bit_cnt <= '0;
        shreg <= '0;
        err_lock <= 1'b0;
      end else if (sample && !err_lock) begin
        if (stuff_violation) begin
          stuff_err <= 1'b1;
          err_lock <= 1'b1;
        end else if (SE0) begin
          byte_err <= bit_cnt != '0;
          bit_cnt <= '0;
          shreg <= '0;
        end else if (bit_valid) begin
          shreg[bit_cnt] <= dbit;
          bit_cnt <= bit_cnt == CW'(BYTE_W - 1) ? '0 : bit_cnt + 1'b1;
          if (bit_cnt == CW'(BYTE_W - 1)) begin
            DataOut <= {dbit, shreg[BYTE_W-2:0]};
            RX_valid <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_rx_deserializer.sv
// tb_rx_deserializer: vector table, directed corner cases and random traffic against a bit-queue model.
module tb_rx_deserializer;
  logic CLK = 1'b0;
  logic RST = 1'b1, sample = 1'b0, J = 1'b0, K = 1'b0, SE0 = 1'b0, shift_en = 1'b0;
  logic [7:0] DataOut;
  logic RX_valid, stuff_err, byte_err;
  int n_chk = 0, n_pass = 0;
  logic m_prev;
  int m_run;
  logic m_bits[$];
  logic m_lock;
  logic [7:0] m_data;
  logic e_valid, e_serr, e_berr;

  typedef struct packed {
    logic r, s, j, k, se0, en, ev, es, eb;
    logic [7:0] ed;
  } vec_t;
  vec_t tbl[18];

  rx_deserializer dut (
    .CLK(CLK), .RST(RST), .sample(sample), .J(J), .K(K), .SE0(SE0), .shift_en(shift_en),
    .DataOut(DataOut), .RX_valid(RX_valid), .stuff_err(stuff_err), .byte_err(byte_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // reference: line history -> decoded bit, run of ones, queue of bits of the current byte
  task automatic model(input logic r, s, j, k, se0, en);
    logic b;
    e_valid = 0; e_serr = 0; e_berr = 0;
    if (r) begin
      m_prev = 0; m_run = 0; m_bits.delete(); m_lock = 0; m_data = 0;
      return;
    end
    if (!en) begin
      m_run = 0; m_bits.delete(); m_lock = 0;
      if (s && !se0 && (j ^ k)) m_prev = k;
      return;
    end
    if (!s) return;
    if (se0) begin
      if (!m_lock) begin
        e_berr = m_bits.size() != 0;
        m_bits.delete();
      end
      m_run = 0;
      return;
    end
    if (!(j ^ k)) return;
    b = (k == m_prev);
    m_prev = k;
    if (m_run == 6) begin
      m_run = 0;
      if (b && !m_lock) begin
        e_serr = 1;
        m_lock = 1;
      end
      return;
    end
    m_run = b ? m_run + 1 : 0;
    if (m_lock) return;
    m_bits.push_back(b);
    if (m_bits.size() == 8) begin
      for (int i = 0; i < 8; i++) m_data[i] = m_bits[i];
      e_valid = 1;
      m_bits.delete();
    end
  endtask

  task automatic cyc(input logic r, s, j, k, se0, en);
    RST = r; sample = s; J = j; K = k; SE0 = se0; shift_en = en;
    model(r, s, j, k, se0, en);
    @(posedge CLK);
    #1;
    chk("rx_valid", {7'd0, RX_valid}, {7'd0, e_valid});
    chk("stuff_err", {7'd0, stuff_err}, {7'd0, e_serr});
    chk("byte_err", {7'd0, byte_err}, {7'd0, e_berr});
    chk("data_out", DataOut, m_data);
  endtask

  task automatic send_bit(input logic b);
    logic k;
    k = b ? m_prev : ~m_prev;
    cyc(0, 1, ~k, k, 0, 1);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  initial begin
    int nv;
    int p;
    logic kk;
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00};
    tbl[1]  = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 8'h00};
    tbl[2]  = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 8'h00};
    tbl[3]  = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 8'h00};
    tbl[4]  = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 8'h00};
    tbl[5]  = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 8'h00};
    tbl[6]  = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 8'h00};
    tbl[7]  = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 8'h00};
    tbl[8]  = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 8'h00};
    tbl[9]  = '{0, 1, 0, 1, 0, 1, 1, 0, 0, 8'hA5};
    tbl[10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 8'hA5};
    tbl[11] = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 8'hA5};
    tbl[12] = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 8'hA5};
    tbl[13] = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 8'hA5};
    tbl[14] = '{0, 1, 0, 0, 1, 1, 0, 0, 1, 8'hA5};
    tbl[15] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 8'hA5};
    tbl[16] = '{0, 1, 0, 0, 1, 1, 0, 0, 0, 8'hA5};
    tbl[17] = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 8'hA5};
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].r, tbl[i].s, tbl[i].j, tbl[i].k, tbl[i].se0, tbl[i].en);
      chk($sformatf("vec%0d_valid", i), {7'd0, RX_valid}, {7'd0, tbl[i].ev});
      chk($sformatf("vec%0d_serr", i), {7'd0, stuff_err}, {7'd0, tbl[i].es});
      chk($sformatf("vec%0d_berr", i), {7'd0, byte_err}, {7'd0, tbl[i].eb});
      chk($sformatf("vec%0d_data", i), DataOut, tbl[i].ed);
    end
    // eight ones with a stuffed zero after the sixth
    cyc(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) send_bit(1);
    send_bit(0);
    send_bit(1);
    chk("stuff_early_valid", {7'd0, RX_valid}, 8'd0);
    send_bit(1);
    chk("stuff_valid", {7'd0, RX_valid}, 8'd1);
    chk("stuff_data", DataOut, 8'hFF);
    chk("stuff_no_err", {7'd0, stuff_err}, 8'd0);
    // seven ones: violation, then locked until shift_en drops
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) send_bit(1);
    chk("viol_serr", {7'd0, stuff_err}, 8'd1);
    nv = 0;
    for (int i = 0; i < 16; i++) begin
      send_bit(1'($urandom_range(1)));
      nv += int'(RX_valid) + int'(stuff_err);
    end
    chk("lock_pulses", 8'(nv), 8'd0);
    cyc(0, 0, 0, 0, 0, 0);
    send_byte(8'h3C);
    chk("unlock_valid", {7'd0, RX_valid}, 8'd1);
    chk("unlock_data", DataOut, 8'h3C);
    // reset mid-byte
    for (int i = 0; i < 5; i++) send_bit(1'(i & 1));
    cyc(1, 1, 0, 1, 0, 1);
    chk("rst_data", DataOut, 8'h00);
    chk("rst_pulses", {5'd0, RX_valid, stuff_err, byte_err}, 8'd0);
    send_byte(8'hA5);
    chk("rst_fresh_valid", {7'd0, RX_valid}, 8'd1);
    chk("rst_fresh_data", DataOut, 8'hA5);
    // shift_en drop mid-byte
    send_byte(8'h5A);
    for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
    cyc(0, 1, 0, 1, 0, 0);
    chk("drop_pulses", {5'd0, RX_valid, stuff_err, byte_err}, 8'd0);
    chk("drop_hold", DataOut, 8'h5A);
    send_byte(8'h0F);
    chk("drop_fresh_valid", {7'd0, RX_valid}, 8'd1);
    chk("drop_fresh_data", DataOut, 8'h0F);
    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      p = int'($urandom_range(99));
      kk = p < 60 ? m_prev : ~m_prev;
      if (p < 88) cyc($urandom_range(999) == 0, $urandom_range(2) == 0, ~kk, kk, 0, $urandom_range(99) != 0);
      else if (p < 93) cyc(0, $urandom_range(2) == 0, 0, 0, 1, $urandom_range(99) != 0);
      else if (p < 96) cyc(0, 1, 0, 0, 0, 1);
      else cyc(0, 1, 1, 1, 0, 1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
